// File: rtl/ser_pkg.sv
// Shared types and helpers for the ser_shift_src parallel-to-serial source.
// Optional parity bit is enabled with the SER_PARITY_EN macro.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LAST  = 2'd2,
    DONE  = 2'd3
  } ser_state_t;

  localparam int unsigned SER_WIDTH_DEFAULT = 8;

  // Bit-counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/ser_bit_cnt.sv
// Tick-gated bit counter with synchronous clear and a terminal-count flag.
// The count saturates at WIDTH-1 instead of wrapping.
module ser_bit_cnt
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH = SER_WIDTH_DEFAULT,
  localparam int unsigned CW   = cnt_width(WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/ser_shift_src.sv
// Parallel-to-serial source driving a downstream enable/data flop pair.
// Define SER_PARITY_EN to append an even-parity bit after the data bits.
module ser_shift_src
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH     = SER_WIDTH_DEFAULT,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             tick,
  output logic             ser_d,
  output logic             ser_en,
  output logic             busy,
  output logic             done
);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             ser_d_q, ser_d_d;
  logic             ser_en_q, ser_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             cnt_clr, cnt_en, cnt_tc;
`ifdef SER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  ser_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
`ifdef SER_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (load_valid && ready_q) begin
          sr_d    = data_in;
          cnt_clr = 1'b1;
          state_d = SHIFT;
`ifdef SER_PARITY_EN
          parity_d = ^data_in;
`endif
        end
      end
      SHIFT: begin
        if (tick) begin
          sr_d   = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
          cnt_en = 1'b1;
          if (cnt_tc) begin
`ifdef SER_PARITY_EN
            state_d = LAST;
`else
            state_d = DONE;
`endif
          end
        end
      end
      LAST: begin
        if (tick) state_d = DONE;
      end
      DONE: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    ser_en_d = (state_d == SHIFT) || (state_d == LAST);
    ser_d_d  = 1'b0;
    if (state_d == SHIFT) begin
      ser_d_d = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];
    end
`ifdef SER_PARITY_EN
    else if (state_d == LAST) begin
      ser_d_d = parity_d;
    end
`endif
    busy_d  = ser_en_d;
    done_d  = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      ser_d_q  <= 1'b0;
      ser_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      ser_d_q  <= ser_d_d;
      ser_en_q <= ser_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

`ifdef SER_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_q <= 1'b0;
    else      parity_q <= parity_d;
  end
`endif

  assign ser_d      = ser_d_q;
  assign ser_en     = ser_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_ready = ready_q;

endmodule

// File: tb/tb_ser_shift_src.sv
// Self-checking bench for ser_shift_src: an MSB-first and an LSB-first instance
// share stimulus; expected bits come from direct indexing of each sent word.
module tb_ser_shift_src;

`ifdef SER_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic m_ready, m_d, m_en, m_busy, m_done;
  logic l_ready, l_d, l_en, l_busy, l_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ser_shift_src #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst_n), .load_valid(load_valid), .load_ready(m_ready),
    .data_in(data_in), .tick(tick), .ser_d(m_d), .ser_en(m_en),
    .busy(m_busy), .done(m_done)
  );

  ser_shift_src #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst_n), .load_valid(load_valid), .load_ready(l_ready),
    .data_in(data_in), .tick(tick), .ser_d(l_d), .ser_en(l_en),
    .busy(l_busy), .done(l_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: bit i of the serial stream, parity position returns even parity.
  function automatic logic exp_bit(input logic [7:0] w, input bit msb, input int i);
    if (i >= 8) return ^w;
    return msb ? w[7-i] : w[i];
  endfunction

  // Vector order: {load_ready, ser_en, ser_d, busy, done}
  task automatic check_idle(input string tag);
    check({tag, "_msb"}, {m_ready, m_en, m_d, m_busy, m_done}, 5'b10000);
    check({tag, "_lsb"}, {l_ready, l_en, l_d, l_busy, l_done}, 5'b10000);
  endtask

  // Starts in an IDLE negedge, ends at the DONE-cycle negedge.
  task automatic run_word(input logic [7:0] w, input int per, input bit hold,
                          input logic [7:0] nxt);
    @(negedge clk);
    check("accept_ready", {m_ready, l_ready}, 2'b11);
    load_valid = 1'b1;
    data_in    = w;
    tick       = 1'($urandom_range(0, 1));
    @(negedge clk);
    tick = 1'b0;
    if (hold) begin
      data_in = nxt;
    end else begin
      load_valid = 1'b0;
      data_in    = 8'($urandom);
    end
    for (int i = 0; i < NBITS; i++) begin
      for (int c = 0; c < per; c++) begin
        check("bit_status_msb", {m_ready, m_en, m_busy, m_done}, 4'b0110);
        check("bit_status_lsb", {l_ready, l_en, l_busy, l_done}, 4'b0110);
        check("bit_msb", m_d, exp_bit(w, 1'b1, i));
        check("bit_lsb", l_d, exp_bit(w, 1'b0, i));
        tick = (c == per - 1);
        @(negedge clk);
      end
    end
    tick = 1'($urandom_range(0, 1));
    check("done_msb", {m_ready, m_en, m_d, m_busy, m_done}, 5'b00001);
    check("done_lsb", {l_ready, l_en, l_d, l_busy, l_done}, 5'b00001);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [7:0] words [10];
    bit         holds [10];

    repeat (2) @(negedge clk);
    check_idle("in_reset");
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_idle("idle");
      tick = 1'($urandom_range(0, 1));
    end
    tick = 1'b0;

    run_word(8'hA5, 4, 1'b0, 8'h00);
    run_word(8'h01, 3, 1'b0, 8'h00);
    run_word(8'h3C, 2, 1'b1, 8'hC3);
    run_word(8'hC3, 1, 1'b0, 8'h00);

    // Abort 8'hFF while its third bit is on the line.
    @(negedge clk);
    load_valid = 1'b1;
    data_in    = 8'hFF;
    @(negedge clk);
    load_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick = c[0];
      @(negedge clk);
    end
    tick = 1'b0;
    check("mid_word_en", {m_en, l_en}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_idle("held_reset");
    end
    rst_n = 1'b1;
    run_word(8'h0F, 2, 1'b0, 8'h00);

    run_word(8'h07, 1, 1'b0, 8'h00);
    run_word(8'h03, 2, 1'b0, 8'h00);

    foreach (words[k]) begin
      words[k] = 8'($urandom);
      holds[k] = 1'($urandom_range(0, 1));
    end
    for (int k = 0; k < 10; k++) begin
      run_word(words[k], int'($urandom_range(1, 4)),
               (k < 9) ? holds[k] : 1'b0, (k < 9) ? words[k+1] : 8'h00);
      if (!((k < 9) && holds[k])) begin
        @(negedge clk);
        check_idle("gap_idle");
      end
    end

    @(negedge clk);
    check_idle("final_idle");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
